// File: rtl/ysyx_23060025_bpu_pkg.sv
// ysyx_23060025_bpu_pkg
//   Shared definitions for the branch prediction unit.
//   - 2-bit saturating counter encodings and the allocation value.
//   - IDU->BPU update bus width and field order. The bus is packed
//     MSB to LSB as {valid, is_br, taken, pc[AW-1:0], target[AW-1:0]}.
//   - Valid-FSM state encoding.
package ysyx_23060025_bpu_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;   // strong not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;   // weak not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;   // weak taken
    localparam logic [1:0] CTR_ST  = 2'b11;   // strong taken

    // A freshly allocated entry starts weakly taken.
    localparam logic [1:0] BPU_RESET_CTR = CTR_WT;

    // Control bits at the top of the update bus: valid, is_br, taken.
    localparam int UPD_CTRL_W = 3;

    function automatic int upd_bus_w(input int addr_w);
        return UPD_CTRL_W + 2 * addr_w;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_e;

endpackage

// File: rtl/ysyx_23060025_sat_ctr2.sv
// ysyx_23060025_sat_ctr2
//   Combinational next-value of a 2-bit saturating up/down counter.
//   Ports:
//     ctr      in   current counter value
//     up       in   1 = count toward strong-taken, 0 = toward strong-not-taken
//     next_ctr out  saturated next value (11 stays 11 on up, 00 stays 00 on down)
module ysyx_23060025_sat_ctr2
    import ysyx_23060025_bpu_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] next_ctr
);

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic inc);
        logic [1:0] r;
        case (c)
            CTR_SNT: r = inc ? CTR_WNT : CTR_SNT;
            CTR_WNT: r = inc ? CTR_WT  : CTR_SNT;
            CTR_WT:  r = inc ? CTR_ST  : CTR_WNT;
            default: r = inc ? CTR_ST  : CTR_WT;
        endcase
        return r;
    endfunction

    assign next_ctr = sat_step(ctr, up);

endmodule

// File: rtl/ysyx_23060025_bpu.sv
// ysyx_23060025_bpu
//   Branch prediction unit ahead of the IFU. A direct-mapped BTB is looked
//   up combinationally with the IFU PC; a hit whose 2-bit counter says taken
//   redirects to the stored target, otherwise the prediction is PC+4.
//   The table is trained by branch/jump resolutions coming from the IDU.
//
//   Ports:
//     clock            in   system clock
//     reset            in   asynchronous active-low reset
//     fs_pc_i          in   PC held by the IFU (lookup key)
//     fire_i           in   IFU accepted the prediction this cycle
//     bpu_valid_o      out  prediction usable (low in reset and first cycle)
//     bpu_pc_predict_o out  predicted next PC
//     upd_valid_i      in   IDU resolution valid
//     upd_pc_i         in   PC of resolved instruction
//     upd_is_br_i      in   resolved instruction is a branch/jump
//     upd_taken_i      in   resolved direction
//     upd_target_i     in   resolved target when taken
//     perf_bus_o       out  {mispredicts, hits, lookups}; only with BPU_PERF_CNT_EN
//
//   Build option: define BPU_PERF_CNT_EN to add the three 32-bit wrapping
//   performance counters and the perf_bus_o port.
module ysyx_23060025_bpu
    import ysyx_23060025_bpu_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int BTB_ENTRIES = 16,
    localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fs_pc_i,
    input  logic                  fire_i,
    output logic                  bpu_valid_o,
    output logic [ADDR_WIDTH-1:0] bpu_pc_predict_o,
    input  logic                  upd_valid_i,
    input  logic [ADDR_WIDTH-1:0] upd_pc_i,
    input  logic                  upd_is_br_i,
    input  logic                  upd_taken_i,
    input  logic [ADDR_WIDTH-1:0] upd_target_i
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [95:0]           perf_bus_o
`endif
);

    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam int UPD_W = upd_bus_w(ADDR_WIDTH);

    bpu_state_e state;

    // Only the valid bits are reset; tag/target/ctr are qualified by valid.
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    // Lookup path
    logic [IDX_W-1:0]      rd_idx;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_hit;
    logic [ADDR_WIDTH-1:0] rd_seq_pc;

    assign rd_idx    = fs_pc_i[IDX_W+1:2];
    assign rd_tag    = fs_pc_i[ADDR_WIDTH-1:IDX_W+2];
    assign rd_hit    = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
    assign rd_seq_pc = fs_pc_i + ADDR_WIDTH'(4);

    // No bypass: a same-cycle update is only visible from the next cycle.
    assign bpu_pc_predict_o = (rd_hit & ctr_q[rd_idx][1]) ? target_q[rd_idx] : rd_seq_pc;

    // Update path: repack the IDU fields into the shared bus layout
    logic [UPD_W-1:0]      upd_bus;
    logic                  upd_v;
    logic                  upd_br;
    logic                  upd_tk;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic [ADDR_WIDTH-1:0] upd_tgt;

    assign upd_bus = {upd_valid_i, upd_is_br_i, upd_taken_i, upd_pc_i, upd_target_i};
    assign upd_v   = upd_bus[UPD_W-1];
    assign upd_br  = upd_bus[UPD_W-2];
    assign upd_tk  = upd_bus[UPD_W-3];
    assign upd_pc  = upd_bus[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign upd_tgt = upd_bus[ADDR_WIDTH-1:0];

    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             upd_en;
    logic [1:0]       ctr_next;

    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];
    assign wr_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);
    // Resolutions arriving before the FSM reaches RUN are dropped.
    assign upd_en = (state == ST_RUN) & upd_v;

    ysyx_23060025_sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_q[wr_idx]),
        .up       (upd_tk),
        .next_ctr (ctr_next)
    );

    // Valid FSM; bpu_valid_o is registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bpu_valid_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state       <= ST_RUN;
                    bpu_valid_o <= 1'b1;
                end
                default: begin
                    state       <= ST_RUN;
                    bpu_valid_o <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (upd_en) begin
            if (upd_br) begin
                if (!wr_hit && upd_tk) begin
                    valid_q[wr_idx] <= 1'b1;
                end
            end else if (wr_hit) begin
                // A non-branch at a predicted PC means the entry is stale.
                valid_q[wr_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (upd_en && upd_br) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_next;
                if (upd_tk) begin
                    target_q[wr_idx] <= upd_tgt;
                end
            end else if (upd_tk) begin
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= upd_tgt;
                ctr_q[wr_idx]    <= BPU_RESET_CTR;
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0]           cnt_lookups;
    logic [31:0]           cnt_hits;
    logic [31:0]           cnt_mispredicts;
    logic [ADDR_WIDTH-1:0] upd_seq_pc;
    logic [ADDR_WIDTH-1:0] upd_pred_pc;
    logic [ADDR_WIDTH-1:0] upd_actual_pc;
    logic                  run;
    logic                  mispredict;

    assign run           = (state == ST_RUN);
    assign upd_seq_pc    = upd_pc + ADDR_WIDTH'(4);
    // What the table currently predicts for the resolved PC.
    assign upd_pred_pc   = (wr_hit & ctr_q[wr_idx][1]) ? target_q[wr_idx] : upd_seq_pc;
    assign upd_actual_pc = upd_tk ? upd_tgt : upd_seq_pc;
    assign mispredict    = upd_en & upd_br & (upd_pred_pc != upd_actual_pc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_lookups     <= '0;
            cnt_hits        <= '0;
            cnt_mispredicts <= '0;
        end else begin
            if (run && fire_i) begin
                cnt_lookups <= cnt_lookups + 32'd1;
            end
            if (run && fire_i && rd_hit) begin
                cnt_hits <= cnt_hits + 32'd1;
            end
            if (mispredict) begin
                cnt_mispredicts <= cnt_mispredicts + 32'd1;
            end
        end
    end

    assign perf_bus_o = {cnt_mispredicts, cnt_hits, cnt_lookups};
`else
    // fire_i and the update PC byte offset only feed the statistics.
    logic unused_perf;
    assign unused_perf = ^{fire_i, upd_pc[1:0]};
`endif

endmodule
